// File: rtl/serial_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, byte strobe and framing error flag.
// Define SERIAL_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module serial_rx #(
  parameter int unsigned BAUD_DIV = 10417,
  parameter int unsigned CNT_W    = $clog2(BAUD_DIV + 1)
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       data_in,
  output logic [7:0] val_out,
  output logic       valid_out,
  output logic       frame_err_out,
  output logic       parity_err_out,
  output logic       busy_out
);

  localparam logic [CNT_W-1:0] HalfLoad = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BitLoad  = CNT_W'(BAUD_DIV - 1);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHi, StParity} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHi} state_e;
`endif

  state_e           state_q;
  logic             sync_q;
  logic             rx_s;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shreg_q;
  logic             parity_ok;

`ifdef SERIAL_RX_PARITY_EN
  logic par_bit_q;
  logic par_err_q;
  assign parity_ok      = ~(^{shreg_q, par_bit_q});
  assign parity_err_out = par_err_q;
`else
  assign parity_ok      = 1'b1;
  assign parity_err_out = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync_q        <= 1'b1;
      rx_s          <= 1'b1;
      state_q       <= StIdle;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      val_out       <= '0;
      valid_out     <= 1'b0;
      frame_err_out <= 1'b0;
      busy_out      <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bit_q     <= 1'b0;
      par_err_q     <= 1'b0;
`endif
    end else begin
      sync_q        <= data_in;
      rx_s          <= sync_q;
      valid_out     <= 1'b0;
      frame_err_out <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_err_q     <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q  <= StStart;
            cnt_q    <= HalfLoad;
            busy_out <= 1'b1;
          end
        end
        StStart: begin
          if (cnt_q == '0) begin
            // Line back high at mid-start means a glitch, not a frame
            if (!rx_s) begin
              state_q   <= StData;
              cnt_q     <= BitLoad;
              bit_idx_q <= '0;
            end else begin
              state_q  <= StIdle;
              busy_out <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StData: begin
          if (cnt_q == '0) begin
            shreg_q <= {rx_s, shreg_q[7:1]};
            cnt_q   <= BitLoad;
            if (bit_idx_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        StParity: begin
          if (cnt_q == '0) begin
            par_bit_q <= rx_s;
            cnt_q     <= BitLoad;
            state_q   <= StStop;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`endif
        StStop: begin
          if (cnt_q == '0) begin
            // Leave at mid-stop so a start bit with no idle gap is still caught
            if (rx_s) begin
              state_q  <= StIdle;
              busy_out <= 1'b0;
              if (parity_ok) begin
                val_out   <= shreg_q;
                valid_out <= 1'b1;
              end else begin
`ifdef SERIAL_RX_PARITY_EN
                par_err_q <= 1'b1;
`endif
              end
            end else begin
              frame_err_out <= 1'b1;
              state_q       <= StWaitHi;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StWaitHi: begin
          if (rx_s) begin
            state_q  <= StIdle;
            busy_out <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Directed self-checking bench for serial_rx at BAUD_DIV=16.
module tb_serial_rx;

  localparam int BD = 16;
`ifdef SERIAL_RX_PARITY_EN
  localparam int FrameBits = 11;
  localparam int Latency   = 2 + BD / 2 + 9 * BD + BD + 1;
`else
  localparam int FrameBits = 10;
  localparam int Latency   = 2 + BD / 2 + 9 * BD + 1;
`endif

  logic       clk_100mhz;
  logic       rst_n;
  logic       data_in;
  logic [7:0] val_out;
  logic       valid_out;
  logic       frame_err_out;
  logic       parity_err_out;
  logic       busy_out;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int valid_cnt = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int busy_cycles = 0;
  int excl_err = 0;
  int valid_cyc[$];
  logic [7:0] valid_val[$];

  serial_rx #(.BAUD_DIV(BD)) dut (
    .clk_in         (clk_100mhz),
    .rst_in         (rst_n),
    .data_in        (data_in),
    .val_out        (val_out),
    .valid_out      (valid_out),
    .frame_err_out  (frame_err_out),
    .parity_err_out (parity_err_out),
    .busy_out       (busy_out)
  );

  initial begin
    clk_100mhz = 1'b0;
    forever #5 clk_100mhz = ~clk_100mhz;
  end

  always @(posedge clk_100mhz) cyc <= cyc + 1;

  // Pulse monitor samples on the falling edge, away from the active edge
  always @(negedge clk_100mhz) begin
    if (valid_out) begin
      valid_cnt++;
      valid_cyc.push_back(cyc);
      valid_val.push_back(val_out);
    end
    if (frame_err_out) fe_cnt++;
    if (parity_err_out) pe_cnt++;
    if (busy_out) busy_cycles++;
    if (int'(valid_out) + int'(frame_err_out) + int'(parity_err_out) > 1) excl_err++;
  end

  task automatic drive_bit(input logic b);
    data_in = b;
    repeat (BD) @(negedge clk_100mhz);
  endtask

  // par_flip inverts the correct even-parity bit when parity is enabled
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored without parity");
`endif
    drive_bit(stop);
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    data_in = 1'b1;
    repeat (3) @(negedge clk_100mhz);
    checks++;
    if (val_out !== 8'h00) begin
      errors++; $display("FAIL reset_val: got %h want 00", val_out);
    end
    checks++;
    if ({valid_out, frame_err_out, parity_err_out, busy_out} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000",
               {valid_out, frame_err_out, parity_err_out, busy_out});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk_100mhz);
  endtask

  task automatic test_basic;
    int vb, fb, s;
    vb = valid_cnt; fb = fe_cnt; s = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (4) @(negedge clk_100mhz);
    checks++;
    if (valid_cnt - vb !== 1) begin
      errors++; $display("FAIL basic_count: got %0d want 1", valid_cnt - vb);
    end
    checks++;
    if (val_out !== 8'hA5) begin
      errors++; $display("FAIL basic_val: got %h want a5", val_out);
    end
    checks++;
    if (fe_cnt - fb !== 0) begin
      errors++; $display("FAIL basic_ferr: got %0d want 0", fe_cnt - fb);
    end
    checks++;
    if (valid_cyc.size() == 0 || valid_cyc[valid_cyc.size() - 1] - s !== Latency) begin
      errors++;
      $display("FAIL basic_latency: got %0d want %0d",
               valid_cyc.size() == 0 ? -1 : valid_cyc[valid_cyc.size() - 1] - s, Latency);
    end
    checks++;
    if (busy_out !== 1'b0) begin
      errors++; $display("FAIL basic_busy: got %b want 0", busy_out);
    end
  endtask

  task automatic test_glitch;
    int vb, fb, pb, bb;
    vb = valid_cnt; fb = fe_cnt; pb = pe_cnt; bb = busy_cycles;
    data_in = 1'b0;
    repeat (4) @(negedge clk_100mhz);
    data_in = 1'b1;
    repeat (30) @(negedge clk_100mhz);
    checks++;
    if ((valid_cnt - vb) + (fe_cnt - fb) + (pe_cnt - pb) !== 0) begin
      errors++;
      $display("FAIL glitch_pulses: got %0d want 0", (valid_cnt - vb) + (fe_cnt - fb) + (pe_cnt - pb));
    end
    checks++;
    if (busy_cycles - bb < 1 || busy_cycles - bb > 9) begin
      errors++; $display("FAIL glitch_busy_len: got %0d want 1..9", busy_cycles - bb);
    end
    checks++;
    if (busy_out !== 1'b0 || val_out !== 8'hA5) begin
      errors++; $display("FAIL glitch_end: got busy=%b val=%h want busy=0 val=a5", busy_out, val_out);
    end
  endtask

  task automatic test_frame_err;
    int vb, fb;
    vb = valid_cnt; fb = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk_100mhz);
    checks++;
    if (fe_cnt - fb !== 1) begin
      errors++; $display("FAIL ferr_count: got %0d want 1", fe_cnt - fb);
    end
    checks++;
    if (valid_cnt - vb !== 0 || val_out !== 8'hA5) begin
      errors++;
      $display("FAIL ferr_noval: got cnt=%0d val=%h want cnt=0 val=a5", valid_cnt - vb, val_out);
    end
    checks++;
    if (busy_out !== 1'b1) begin
      errors++; $display("FAIL ferr_waithi_busy: got %b want 1", busy_out);
    end
    data_in = 1'b1;
    repeat (8) @(negedge clk_100mhz);
    checks++;
    if (busy_out !== 1'b0 || fe_cnt - fb !== 1) begin
      errors++;
      $display("FAIL ferr_release: got busy=%b fe=%0d want busy=0 fe=1", busy_out, fe_cnt - fb);
    end
  endtask

  task automatic test_back_to_back;
    int vb, n;
    vb = valid_cnt;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (4) @(negedge clk_100mhz);
    n = valid_cyc.size();
    checks++;
    if (valid_cnt - vb !== 2) begin
      errors++; $display("FAIL b2b_count: got %0d want 2", valid_cnt - vb);
    end
    checks++;
    if (n < 2 || valid_val[n - 2] !== 8'h00 || valid_val[n - 1] !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_vals: got %h,%h want 00,ff",
               n < 2 ? 8'hxx : valid_val[n - 2], n < 1 ? 8'hxx : valid_val[n - 1]);
    end
    checks++;
    if (n < 2 || valid_cyc[n - 1] - valid_cyc[n - 2] !== FrameBits * BD) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d want %0d",
               n < 2 ? -1 : valid_cyc[n - 1] - valid_cyc[n - 2], FrameBits * BD);
    end
  endtask

  task automatic test_reset_midframe;
    int vb, fb, pb;
    vb = valid_cnt; fb = fe_cnt; pb = pe_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    data_in = 1'b0;
    repeat (8) @(negedge clk_100mhz);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({val_out, valid_out, frame_err_out, parity_err_out, busy_out} !== 12'h000) begin
      errors++;
      $display("FAIL midrst_async: got val=%h flags=%b want 00/0000", val_out,
               {valid_out, frame_err_out, parity_err_out, busy_out});
    end
    repeat (8) @(negedge clk_100mhz);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    data_in = 1'b1;
    repeat (4) @(negedge clk_100mhz);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk_100mhz);
    drive_bit(1'b1);
    drive_bit(1'b1);
    repeat (40) @(negedge clk_100mhz);
    checks++;
    if ((valid_cnt - vb) + (fe_cnt - fb) + (pe_cnt - pb) !== 0) begin
      errors++;
      $display("FAIL midrst_pulses: got %0d want 0", (valid_cnt - vb) + (fe_cnt - fb) + (pe_cnt - pb));
    end
    checks++;
    if (val_out !== 8'h00 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL midrst_end: got val=%h busy=%b want 00/0", val_out, busy_out);
    end
  endtask

`ifdef SERIAL_RX_PARITY_EN
  task automatic test_parity;
    int vb, pb;
    vb = valid_cnt; pb = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk_100mhz);
    checks++;
    if (pe_cnt - pb !== 1 || valid_cnt - vb !== 0) begin
      errors++;
      $display("FAIL parity_bad: got pe=%0d valid=%0d want 1/0", pe_cnt - pb, valid_cnt - vb);
    end
    checks++;
    if (val_out !== 8'h00) begin
      errors++; $display("FAIL parity_bad_val: got %h want 00", val_out);
    end
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (4) @(negedge clk_100mhz);
    checks++;
    if (valid_cnt - vb !== 1 || val_out !== 8'h07 || pe_cnt - pb !== 1) begin
      errors++;
      $display("FAIL parity_good: got valid=%0d val=%h pe=%0d want 1/07/1",
               valid_cnt - vb, val_out, pe_cnt - pb);
    end
  endtask
`else
  task automatic test_parity_off;
    checks++;
    if (pe_cnt !== 0) begin
      errors++; $display("FAIL parity_tied: got %0d pulses want 0", pe_cnt);
    end
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    data_in = 1'b1;
    @(negedge clk_100mhz);
    test_reset;
    test_basic;
    test_glitch;
    test_frame_err;
    test_back_to_back;
    test_reset_midframe;
`ifdef SERIAL_RX_PARITY_EN
    test_parity;
`else
    test_parity_off;
`endif
    checks++;
    if (excl_err !== 0) begin
      errors++; $display("FAIL pulse_exclusive: got %0d overlaps want 0", excl_err);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
